wb_stage: RTL and testbench

Writeback stage of the five-stage RV32I pipeline, sitting between the MEM stage and the register file. It latches the MEM/WB pipeline register and selects the writeback source: ALU result, aligned/extended load data, or PC+4. It drives the register file's write port (`reg_we`, `w_addr`, `w_data`) exactly once per retired instruction and maintains a 64-bit retired-instruction counter.

---
 rtl/wb_stage.sv | 146 ++++++++++++++
 tb/tb_wb_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, writeback source select, register file write port and retired-instruction counter.
// Optional macro WB_BYPASS_EN adds same-cycle WB->ID forwarding ports.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_rd_we,
    input  logic [4:0]      mem_rd_addr,
    input  logic [1:0]      mem_wb_sel,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            wb_stall,
    output logic            reg_we,
    output logic [4:0]      w_addr,
    output logic [XLEN-1:0] w_data,
    output logic            wb_valid,
    output logic            load_misalign,
    output logic [63:0]     instret
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_rf_data,
    input  logic [XLEN-1:0] rs2_rf_data,
    output logic [XLEN-1:0] rs1_fwd_data,
    output logic [XLEN-1:0] rs2_fwd_data
`endif
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic            r_valid;
    logic            r_rdWe;
    logic [4:0]      r_rd;
    logic [1:0]      r_sel;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rdata;
    logic            r_done;
    logic [63:0]     r_instret;

    logic [1:0]      w_off;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_loadData;
    logic            w_misalign;
    logic            w_retire;
    logic [XLEN-1:0] w_wbData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_rdWe   <= 1'b0;
            r_rd     <= '0;
            r_sel    <= '0;
            r_funct3 <= '0;
            r_alu    <= '0;
            r_pc     <= '0;
            r_rdata  <= '0;
            r_done   <= 1'b0;
        end else if (!wb_stall) begin
            r_valid  <= mem_valid;
            r_rdWe   <= mem_rd_we;
            r_rd     <= mem_rd_addr;
            r_sel    <= mem_wb_sel;
            r_funct3 <= mem_funct3;
            r_alu    <= mem_alu_result;
            r_pc     <= mem_pc;
            r_rdata  <= mem_rdata;
            r_done   <= 1'b0;
        end else if (w_retire) begin
            // A held entry retires once; later stalled cycles must not write or count again.
            r_done   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign w_off = r_alu[1:0];

    always_comb begin
        w_byte = r_rdata[7:0];
        case (w_off)
            2'd0: w_byte = r_rdata[7:0];
            2'd1: w_byte = r_rdata[15:8];
            2'd2: w_byte = r_rdata[23:16];
            2'd3: w_byte = r_rdata[31:24];
            default: w_byte = r_rdata[7:0];
        endcase
        w_half = w_off[1] ? r_rdata[31:16] : r_rdata[15:0];
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_loadData = {24'd0, w_byte};
            3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
            3'b101:  w_loadData = {16'd0, w_half};
            default: w_loadData = r_rdata;
        endcase
    end

    always_comb begin
        w_misalign = 1'b0;
        if (r_valid && r_sel == SEL_LOAD) begin
            if ((r_funct3 == 3'b001 || r_funct3 == 3'b101) && w_off[0])
                w_misalign = 1'b1;
            else if (r_funct3 == 3'b010 && w_off != 2'd0)
                w_misalign = 1'b1;
        end
    end

    always_comb begin
        case (r_sel)
            SEL_ALU:  w_wbData = r_alu;
            SEL_LOAD: w_wbData = w_loadData;
            SEL_PC4:  w_wbData = r_pc + 32'd4;
            default:  w_wbData = '0;
        endcase
    end

    assign w_retire      = r_valid && !r_done && !w_misalign;
    assign reg_we        = w_retire && r_rdWe && (r_rd != 5'd0);
    assign w_addr        = r_rd;
    assign w_data        = w_wbData;
    assign wb_valid      = r_valid;
    assign load_misalign = w_misalign;
    assign instret       = r_instret;

`ifdef WB_BYPASS_EN
    // The register file reads asynchronously, so a same-cycle write must be forwarded here.
    assign rs1_fwd_data = (reg_we && w_addr == rs1_addr) ? w_data : rs1_rf_data;
    assign rs2_fwd_data = (reg_we && w_addr == rs2_addr) ? w_data : rs2_rf_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: vector table with an expected-result queue, plus reset, stall and bypass sequences.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_rd_we;
    logic [4:0]  mem_rd_addr;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;
    logic        wb_stall;
    logic        reg_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic        wb_valid;
    logic        load_misalign;
    logic [63:0] instret;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rf_data;
    logic [31:0] rs2_rf_data;
    logic [31:0] rs1_fwd_data;
    logic [31:0] rs2_fwd_data;
`endif

    wb_stage #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .mem_valid(mem_valid),
        .mem_rd_we(mem_rd_we),
        .mem_rd_addr(mem_rd_addr),
        .mem_wb_sel(mem_wb_sel),
        .mem_funct3(mem_funct3),
        .mem_alu_result(mem_alu_result),
        .mem_pc(mem_pc),
        .mem_rdata(mem_rdata),
        .wb_stall(wb_stall),
        .reg_we(reg_we),
        .w_addr(w_addr),
        .w_data(w_data),
        .wb_valid(wb_valid),
        .load_misalign(load_misalign),
        .instret(instret)
`ifdef WB_BYPASS_EN
        ,
        .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr),
        .rs1_rf_data(rs1_rf_data),
        .rs2_rf_data(rs2_rf_data),
        .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_data(rs2_fwd_data)
`endif
    );

    typedef struct {
        logic        valid;
        logic        rdWe;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        expWe;
        logic [31:0] expData;
        logic        expMis;
        logic        expInc;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mis;
        logic [63:0] cnt;
    } exp_t;

    vec_t  vecs[16];
    exp_t  expQ[$];
    int    checks;
    int    errors;
    longint unsigned modelCnt;

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    function automatic vec_t mk(input logic v, input logic we, input logic [4:0] rd,
                                input logic [1:0] sel, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] pc,
                                input logic [31:0] rdata, input logic eWe,
                                input logic [31:0] eData, input logic eMis,
                                input logic eInc);
        vec_t r;
        r.valid = v;   r.rdWe = we;   r.rd = rd;   r.sel = sel;   r.f3 = f3;
        r.alu = alu;   r.pc = pc;     r.rdata = rdata;
        r.expWe = eWe; r.expData = eData; r.expMis = eMis; r.expInc = eInc;
        return r;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic driveMem(input logic v, input logic we, input logic [4:0] rd,
                            input logic [1:0] sel, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [31:0] pc,
                            input logic [31:0] rdata);
        mem_valid = v;  mem_rd_we = we;  mem_rd_addr = rd;  mem_wb_sel = sel;
        mem_funct3 = f3; mem_alu_result = alu; mem_pc = pc; mem_rdata = rdata;
    endtask

    // Drive one instruction, queue what WB must show after it is captured, then wait for the capture.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        wb_stall = 1'b0;
        driveMem(v.valid, v.rdWe, v.rd, v.sel, v.f3, v.alu, v.pc, v.rdata);
        e.we   = v.expWe;
        e.addr = v.rd;
        e.data = v.expData;
        e.mis  = v.expMis;
        e.cnt  = modelCnt;
        expQ.push_back(e);
        if (v.expInc) modelCnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        string tag;
        if (expQ.size() == 0) begin
            checkVal("queue_empty", 64'd1, 64'd0);
            return;
        end
        e = expQ.pop_front();
        tag = $sformatf("v%0d", idx);
        checkVal({tag, "_reg_we"}, {63'd0, reg_we}, {63'd0, e.we});
        checkVal({tag, "_w_addr"}, {59'd0, w_addr}, {59'd0, e.addr});
        checkVal({tag, "_w_data"}, {32'd0, w_data}, {32'd0, e.data});
        checkVal({tag, "_misalign"}, {63'd0, load_misalign}, {63'd0, e.mis});
        checkVal({tag, "_instret"}, instret, e.cnt);
    endtask

    initial begin
        int weHigh;
        longint unsigned cntBefore;
        checks = 0;
        errors = 0;
        modelCnt = 0;
        rst = 1'b1;
        wb_stall = 1'b0;
        driveMem(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
`ifdef WB_BYPASS_EN
        rs1_addr = 5'd9;  rs2_addr = 5'd3;
        rs1_rf_data = 32'h1111_1111;  rs2_rf_data = 32'h2222_2222;
`endif

        vecs[0]  = mk(1, 1, 5'd5,  2'b00, 3'b000, 32'h1234_5678, 32'h0,   32'h0, 1, 32'h1234_5678, 0, 1);
        vecs[1]  = mk(1, 1, 5'd10, 2'b01, 3'b000, 32'h0000_1003, 32'h0,   RD,    1, 32'hFFFF_FF80, 0, 1);
        vecs[2]  = mk(1, 1, 5'd10, 2'b01, 3'b100, 32'h0000_1002, 32'h0,   RD,    1, 32'h0000_00FF, 0, 1);
        vecs[3]  = mk(1, 1, 5'd12, 2'b01, 3'b001, 32'h0000_1002, 32'h0,   RD,    1, 32'hFFFF_80FF, 0, 1);
        vecs[4]  = mk(1, 1, 5'd13, 2'b01, 3'b101, 32'h0000_1000, 32'h0,   RD,    1, 32'h0000_7F01, 0, 1);
        vecs[5]  = mk(1, 1, 5'd14, 2'b01, 3'b010, 32'h0000_1002, 32'h0,   RD,    0, RD,            1, 0);
        vecs[6]  = mk(1, 1, 5'd15, 2'b01, 3'b001, 32'h0000_1001, 32'h0,   RD,    0, 32'h0000_7F01, 1, 0);
        vecs[7]  = mk(1, 1, 5'd16, 2'b01, 3'b000, 32'h0000_1001, 32'h0,   RD,    1, 32'h0000_007F, 0, 1);
        vecs[8]  = mk(1, 1, 5'd17, 2'b01, 3'b011, 32'h0000_1002, 32'h0,   RD,    1, RD,            0, 1);
        vecs[9]  = mk(1, 1, 5'd0,  2'b10, 3'b000, 32'h0,         32'h100, 32'h0, 0, 32'h0000_0104, 0, 1);
        vecs[10] = mk(1, 1, 5'd1,  2'b10, 3'b000, 32'h0, 32'hFFFF_FFFC,   32'h0, 1, 32'h0000_0000, 0, 1);
        vecs[11] = mk(1, 1, 5'd3,  2'b11, 3'b000, 32'h99,        32'h40,  32'h0, 1, 32'h0000_0000, 0, 1);
        vecs[12] = mk(0, 1, 5'd4,  2'b00, 3'b000, 32'h55,        32'h0,   32'h0, 0, 32'h0000_0055, 0, 0);
        vecs[13] = mk(0, 1, 5'd4,  2'b01, 3'b010, 32'h0000_1002, 32'h0,   RD,    0, RD,            0, 0);
        vecs[14] = mk(1, 0, 5'd6,  2'b00, 3'b000, 32'h66,        32'h0,   32'h0, 0, 32'h0000_0066, 0, 1);
        vecs[15] = mk(1, 1, 5'd11, 2'b01, 3'b010, 32'h0000_2000, 32'h0,   RD,    1, RD,            0, 1);

        #1;
        checkVal("reset_reg_we", {63'd0, reg_we}, 64'd0);
        checkVal("reset_w_data", {32'd0, w_data}, 64'd0);
        checkVal("reset_wb_valid", {63'd0, wb_valid}, 64'd0);
        checkVal("reset_instret", instret, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // Reset in the middle of a live writeback must clear outputs before any edge.
        @(negedge clk);
        driveMem(1, 1, 5'd20, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        checkVal("pre_rst_reg_we", {63'd0, reg_we}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkVal("midrst_reg_we", {63'd0, reg_we}, 64'd0);
        checkVal("midrst_w_data", {32'd0, w_data}, 64'd0);
        checkVal("midrst_w_addr", {59'd0, w_addr}, 64'd0);
        checkVal("midrst_instret", instret, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        modelCnt = 0;

        // Three-cycle stall on rd=7 with the next instruction waiting at the MEM inputs.
        @(negedge clk);
        wb_stall = 1'b0;
        driveMem(1, 1, 5'd7, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        cntBefore = instret;
        weHigh = reg_we ? 1 : 0;
        checkVal("stall_first_we", {63'd0, reg_we}, 64'd1);
        checkVal("stall_first_addr", {59'd0, w_addr}, 64'd7);
        @(negedge clk);
        wb_stall = 1'b1;
        driveMem(1, 1, 5'd8, 2'b00, 3'b000, 32'h0000_0088, 32'h0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            if (reg_we) weHigh++;
            checkVal($sformatf("stall_hold%0d_we", c), {63'd0, reg_we}, 64'd0);
            checkVal($sformatf("stall_hold%0d_addr", c), {59'd0, w_addr}, 64'd7);
            checkVal($sformatf("stall_hold%0d_instret", c), instret, cntBefore + 64'd1);
        end
        checkVal("stall_we_cycles", 64'(weHigh), 64'd1);
        @(negedge clk);
        wb_stall = 1'b0;
        @(posedge clk);
        #1;
        checkVal("release_addr", {59'd0, w_addr}, 64'd8);
        checkVal("release_data", {32'd0, w_data}, 64'h88);
        checkVal("release_we", {63'd0, reg_we}, 64'd1);
        checkVal("release_instret", instret, cntBefore + 64'd1);

`ifdef WB_BYPASS_EN
        @(negedge clk);
        driveMem(1, 1, 5'd9, 2'b00, 3'b000, 32'h0000_00AA, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        checkVal("byp_match", {32'd0, rs1_fwd_data}, 64'hAA);
        checkVal("byp_rs2_pass", {32'd0, rs2_fwd_data}, 64'h2222_2222);
        @(negedge clk);
        driveMem(1, 1, 5'd0, 2'b00, 3'b000, 32'h0000_00AA, 32'h0, 32'h0);
        rs1_addr = 5'd0;
        @(posedge clk);
        #1;
        checkVal("byp_x0_pass", {32'd0, rs1_fwd_data}, 64'h1111_1111);
`endif

        checkVal("queue_drained", 64'(expQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
